// File: rtl/mem_port_arbiter_pkg.sv
// Shared types and constants for the IF/DM memory port arbiter.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package mem_arb_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        RESP  = 2'd3
    } arb_state_t;

    // Requester ids held in the grant register
    localparam logic GNT_IF = 1'b0;
    localparam logic GNT_DM = 1'b1;

    // Width of the memory latency counter; holds LATENCY up to 15
    localparam int CNT_W = 4;

endpackage

// File: rtl/mem_port_arbiter_if.sv
// Bundles the IF requester, DM requester and memory command/response signals.
// Latency: n/a (wiring only).
// Backpressure: requesters hold req until their ack; stall = req & ~ack.
// Modports: master = the arbiter (serves requesters, drives the memory),
//           slave  = the environment (requesters plus memory).
interface mem_port_arbiter_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    // instruction-fetch requester
    logic              if_req_i;
    logic [ADDR_W-1:0] if_addr_i;
    logic              if_ack_o;
    logic [DATA_W-1:0] if_rdata_o;
    logic              if_stall_o;
    // data-memory requester
    logic              dm_req_i;
    logic              dm_we_i;
    logic [ADDR_W-1:0] dm_addr_i;
    logic [DATA_W-1:0] dm_wdata_i;
    logic              dm_ack_o;
    logic [DATA_W-1:0] dm_rdata_o;
    logic              dm_stall_o;
    // memory side
    logic              mem_req_o;
    logic              mem_we_o;
    logic [ADDR_W-1:0] mem_addr_o;
    logic [DATA_W-1:0] mem_wdata_o;
    logic [DATA_W-1:0] mem_rdata_i;

    modport master (
        input  if_req_i, if_addr_i,
        input  dm_req_i, dm_we_i, dm_addr_i, dm_wdata_i,
        input  mem_rdata_i,
        output if_ack_o, if_rdata_o, if_stall_o,
        output dm_ack_o, dm_rdata_o, dm_stall_o,
        output mem_req_o, mem_we_o, mem_addr_o, mem_wdata_o
    );

    modport slave (
        output if_req_i, if_addr_i,
        output dm_req_i, dm_we_i, dm_addr_i, dm_wdata_i,
        output mem_rdata_i,
        input  if_ack_o, if_rdata_o, if_stall_o,
        input  dm_ack_o, dm_rdata_o, dm_stall_o,
        input  mem_req_o, mem_we_o, mem_addr_o, mem_wdata_o
    );

endinterface

// File: rtl/mem_port_arbiter_lat_cnt.sv
// Loadable down-counter that times the fixed memory latency (module arb_lat_cnt).
// Latency: load takes effect next cycle; zero is combinational from count and dec.
// Backpressure: none; counts only while dec is high.
// Ports: clk_i, rst_i (sync, active-high), load, dec, zero.
module arb_lat_cnt
    import mem_arb_pkg::*;
#(
    parameter int LATENCY = 2
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic load,
    input  logic dec,
    output logic zero
);

    logic [CNT_W-1:0] cnt;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            cnt <= '0;
        end else if (load) begin
            cnt <= CNT_W'(LATENCY);
        end else if (dec && (cnt != '0)) begin
            cnt <= cnt - CNT_W'(1);
        end
    end

    // Flags the cycle whose decrement takes the count to zero, i.e. the last
    // WAIT cycle, which is exactly when memory data is valid.
    assign zero = dec && (cnt == CNT_W'(1));

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one fixed-latency single-port memory between IF and DM requesters.
// Latency: req to ack is LATENCY+3 cycles uncontended (IDLE, ISSUE, WAIT x LATENCY, RESP).
// Backpressure: requesters hold req until ack; stall outputs = req & ~ack.
// Ports: clk_i, rst_i (sync, active-high), bus (mem_port_arbiter_if.master).
// Build option: define ARB_RR_EN to alternate priority when both requests are
// pending in IDLE; without it DM always wins in IDLE.
module mem_port_arbiter
    import mem_arb_pkg::*;
#(
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32,
    parameter int LATENCY = 2
) (
    input  logic                clk_i,
    input  logic                rst_i,
    mem_port_arbiter_if.master  bus
);

    arb_state_t        state, state_nxt;
    logic              gnt;            // requester currently (or last) served
    logic              pick;           // IDLE arbitration winner
    logic              load;           // latch a new access this cycle
    logic              ld_id;          // id of the access being latched
    logic              cnt_load;
    logic              cnt_dec;
    logic              cnt_zero;
    logic              capture;        // memory data valid this cycle
    logic              mem_we_q;
    logic [ADDR_W-1:0] mem_addr_q;
    logic [DATA_W-1:0] mem_wdata_q;
    logic [DATA_W-1:0] if_rdata_q;
    logic [DATA_W-1:0] dm_rdata_q;

    arb_lat_cnt #(.LATENCY(LATENCY)) u_lat_cnt (
        .clk_i (clk_i),
        .rst_i (rst_i),
        .load  (cnt_load),
        .dec   (cnt_dec),
        .zero  (cnt_zero)
    );

    // IDLE winner. DM wins by default: it belongs to the older instruction.
    always_comb begin
        pick = bus.dm_req_i ? GNT_DM : GNT_IF;
`ifdef ARB_RR_EN
        if (bus.dm_req_i && bus.if_req_i) begin
            pick = (gnt == GNT_DM) ? GNT_IF : GNT_DM;
        end
`endif
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        load      = 1'b0;
        ld_id     = gnt;
        cnt_load  = 1'b0;
        cnt_dec   = 1'b0;
        capture   = 1'b0;
        case (state)
            IDLE: begin
                if (bus.dm_req_i || bus.if_req_i) begin
                    load      = 1'b1;
                    ld_id     = pick;
                    state_nxt = ISSUE;
                end
            end
            ISSUE: begin
                cnt_load  = 1'b1;
                state_nxt = WAIT;
            end
            WAIT: begin
                cnt_dec = 1'b1;
                if (cnt_zero) begin
                    capture   = 1'b1;
                    state_nxt = RESP;
                end
            end
            RESP: begin
                // The served requester still has req high this cycle, so only
                // the other one may chain a back-to-back access.
                state_nxt = IDLE;
                if ((gnt == GNT_DM) ? bus.if_req_i : bus.dm_req_i) begin
                    load      = 1'b1;
                    ld_id     = ~gnt;
                    state_nxt = ISSUE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Access fields and response words. Command fields hold between accesses;
    // an IF access leaves the write-data register untouched.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            gnt         <= GNT_DM;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            if_rdata_q  <= '0;
            dm_rdata_q  <= '0;
        end else begin
            if (load) begin
                gnt <= ld_id;
                if (ld_id == GNT_DM) begin
                    mem_we_q    <= bus.dm_we_i;
                    mem_addr_q  <= bus.dm_addr_i;
                    mem_wdata_q <= bus.dm_wdata_i;
                end else begin
                    mem_we_q   <= 1'b0;
                    mem_addr_q <= bus.if_addr_i;
                end
            end
            if (capture) begin
                if (gnt == GNT_IF) begin
                    if_rdata_q <= bus.mem_rdata_i;
                end else if (!mem_we_q) begin
                    dm_rdata_q <= bus.mem_rdata_i;
                end
            end
        end
    end

    assign bus.mem_req_o   = (state == ISSUE);
    assign bus.mem_we_o    = mem_we_q;
    assign bus.mem_addr_o  = mem_addr_q;
    assign bus.mem_wdata_o = mem_wdata_q;

    assign bus.if_ack_o    = (state == RESP) && (gnt == GNT_IF);
    assign bus.dm_ack_o    = (state == RESP) && (gnt == GNT_DM);
    assign bus.if_rdata_o  = if_rdata_q;
    assign bus.dm_rdata_o  = dm_rdata_q;

    assign bus.if_stall_o  = bus.if_req_i & ~bus.if_ack_o;
    assign bus.dm_stall_o  = bus.dm_req_i & ~bus.dm_ack_o;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: one instance at LATENCY=2, one at LATENCY=1,
// each with a small behavioural memory that returns data LATENCY cycles after mem_req_o.
// Inputs are driven 1 time unit after posedge, outputs sampled on negedge.
module tb_mem_port_arbiter;

    localparam logic [31:0] FILLER = 32'hBAD0_BAD0;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_tests = 0;
    int   n_fail  = 0;
    bit   w_dm;

    always #5 clk = ~clk;

    mem_port_arbiter_if #(.ADDR_W(32), .DATA_W(32)) bus2 ();
    mem_port_arbiter_if #(.ADDR_W(32), .DATA_W(32)) bus1 ();

    mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .LATENCY(2)) u_dut2 (
        .clk_i (clk),
        .rst_i (rst),
        .bus   (bus2.master)
    );

    mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .LATENCY(1)) u_dut1 (
        .clk_i (clk),
        .rst_i (rst),
        .bus   (bus1.master)
    );

    // ---------------- behavioural memory ----------------
    logic [31:0] mem [logic [31:0]];
    logic [32:0] p2 [0:1];
    logic [32:0] p1;

    function automatic logic [31:0] rd(input logic [31:0] a);
        if (mem.exists(a)) return mem[a];
        return 32'hA5A5_0000 ^ a;
    endfunction

    always @(posedge clk) begin
        if (bus2.mem_req_o && bus2.mem_we_o) mem[bus2.mem_addr_o] = bus2.mem_wdata_o;
    end

    always @(posedge clk) begin
        if (rst) begin
            p2[0] <= '0;
            p2[1] <= '0;
            p1    <= '0;
        end else begin
            p2[0] <= {bus2.mem_req_o, rd(bus2.mem_addr_o)};
            p2[1] <= p2[0];
            p1    <= {bus1.mem_req_o, rd(bus1.mem_addr_o)};
        end
    end

    assign bus2.mem_rdata_i = p2[1][32] ? p2[1][31:0] : FILLER;
    assign bus1.mem_rdata_i = p1[32]    ? p1[31:0]    : FILLER;

    // ---------------- checking ----------------
    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        bus2.if_req_i = 0; bus2.if_addr_i = 0;
        bus2.dm_req_i = 0; bus2.dm_we_i = 0; bus2.dm_addr_i = 0; bus2.dm_wdata_i = 0;
        bus1.if_req_i = 0; bus1.if_addr_i = 0;
        bus1.dm_req_i = 0; bus1.dm_we_i = 0; bus1.dm_addr_i = 0; bus1.dm_wdata_i = 0;
        mem[32'h10] = 32'h2010_0004;
        mem[32'h20] = 32'hCAFE_0020;
        mem[32'h80] = 32'h0000_1234;
`ifdef ARB_RR_EN
        w_dm = 1'b0;
`else
        w_dm = 1'b1;
`endif
        repeat (3) @(posedge clk);
        #1 rst = 0;

        // ---- reset state ----
        @(negedge clk);
        check("rst mem_req",   bus2.mem_req_o,   0);
        check("rst mem_we",    bus2.mem_we_o,    0);
        check("rst mem_addr",  bus2.mem_addr_o,  0);
        check("rst mem_wdata", bus2.mem_wdata_o, 0);
        check("rst if_ack",    bus2.if_ack_o,    0);
        check("rst dm_ack",    bus2.dm_ack_o,    0);
        check("rst if_rdata",  bus2.if_rdata_o,  0);
        check("rst dm_rdata",  bus2.dm_rdata_o,  0);
        check("rst l1 mem_req", bus1.mem_req_o,  0);
        next_cycle();

        // ---- T1: IF read 0x10 alone ----
        bus2.if_req_i = 1; bus2.if_addr_i = 32'h10;
        for (int c = 0; c <= 6; c++) begin
            @(negedge clk);
            check($sformatf("t1 if_stall c%0d", c), bus2.if_stall_o, (c <= 3));
            check($sformatf("t1 mem_req c%0d", c),  bus2.mem_req_o,  (c == 1));
            check($sformatf("t1 if_ack c%0d", c),   bus2.if_ack_o,   (c == 4));
            check($sformatf("t1 dm_ack c%0d", c),   bus2.dm_ack_o,   0);
            if (c == 1) begin
                check("t1 mem_addr", bus2.mem_addr_o, 32'h10);
                check("t1 mem_we",   bus2.mem_we_o,   0);
            end
            if (c == 4) check("t1 if_rdata", bus2.if_rdata_o, 32'h2010_0004);
            next_cycle();
            if (c == 4) bus2.if_req_i = 0;
        end

        // ---- T3: simultaneous IF + DM in IDLE (last grant IF, so DM first either way) ----
        bus2.if_req_i = 1; bus2.if_addr_i = 32'h10;
        bus2.dm_req_i = 1; bus2.dm_we_i = 0; bus2.dm_addr_i = 32'h20;
        for (int c = 0; c <= 9; c++) begin
            @(negedge clk);
            check($sformatf("t3 mem_req c%0d", c),  bus2.mem_req_o,  (c == 1) || (c == 5));
            check($sformatf("t3 dm_ack c%0d", c),   bus2.dm_ack_o,   (c == 4));
            check($sformatf("t3 if_ack c%0d", c),   bus2.if_ack_o,   (c == 8));
            check($sformatf("t3 if_stall c%0d", c), bus2.if_stall_o, (c <= 7));
            if (c == 1) check("t3 dm addr", bus2.mem_addr_o, 32'h20);
            if (c == 5) check("t3 if addr", bus2.mem_addr_o, 32'h10);
            if (c == 4) begin
                check("t3 dm_rdata",      bus2.dm_rdata_o, 32'hCAFE_0020);
                check("t3 if_rdata hold", bus2.if_rdata_o, 32'h2010_0004);
            end
            if (c == 8) check("t3 if_rdata", bus2.if_rdata_o, 32'h2010_0004);
            next_cycle();
            if (c == 4) bus2.dm_req_i = 0;
            if (c == 8) bus2.if_req_i = 0;
        end

        // ---- T2: DM write 0x40 <= DEADBEEF ----
        bus2.dm_req_i = 1; bus2.dm_we_i = 1; bus2.dm_addr_i = 32'h40; bus2.dm_wdata_i = 32'hDEAD_BEEF;
        for (int c = 0; c <= 6; c++) begin
            @(negedge clk);
            check($sformatf("t2 mem_req c%0d", c),  bus2.mem_req_o,  (c == 1));
            check($sformatf("t2 dm_ack c%0d", c),   bus2.dm_ack_o,   (c == 4));
            check($sformatf("t2 if_ack c%0d", c),   bus2.if_ack_o,   0);
            check($sformatf("t2 dm_stall c%0d", c), bus2.dm_stall_o, (c <= 3));
            if (c == 1 || c == 6) begin
                check($sformatf("t2 mem_we c%0d", c),    bus2.mem_we_o,    1);
                check($sformatf("t2 mem_addr c%0d", c),  bus2.mem_addr_o,  32'h40);
                check($sformatf("t2 mem_wdata c%0d", c), bus2.mem_wdata_o, 32'hDEAD_BEEF);
            end
            next_cycle();
            if (c == 4) begin bus2.dm_req_i = 0; bus2.dm_we_i = 0; end
        end

        // ---- T4: both held continuously from IDLE (last grant DM) ----
        // Fixed priority: DM first; round-robin: IF first. Acks every LATENCY+2.
        // Both drop after the 4th ack; the 5th access already chained still acks.
        bus2.if_req_i = 1; bus2.if_addr_i = 32'h10;
        bus2.dm_req_i = 1; bus2.dm_we_i = 0; bus2.dm_addr_i = 32'h20;
        for (int c = 0; c <= 21; c++) begin
            bit slot, e_dm, e_if, iss, iss_dm;
            @(negedge clk);
            slot   = (c % 4 == 0) && (c >= 4) && (c <= 20);
            e_dm   = slot && ((((c / 4) % 2) == 1) == w_dm);
            e_if   = slot && !e_dm;
            iss    = (c % 4 == 1) && (c <= 17);
            iss_dm = ((((c - 1) / 4 + 1) % 2) == 1) == w_dm;
            check($sformatf("t4 dm_ack c%0d", c),   bus2.dm_ack_o,   e_dm);
            check($sformatf("t4 if_ack c%0d", c),   bus2.if_ack_o,   e_if);
            check($sformatf("t4 mem_req c%0d", c),  bus2.mem_req_o,  iss);
            check($sformatf("t4 if_stall c%0d", c), bus2.if_stall_o, (c <= 16) && !e_if);
            check($sformatf("t4 dm_stall c%0d", c), bus2.dm_stall_o, (c <= 16) && !e_dm);
            if (iss)  check($sformatf("t4 mem_addr c%0d", c), bus2.mem_addr_o, iss_dm ? 32'h20 : 32'h10);
            if (e_dm) check($sformatf("t4 dm_rdata c%0d", c), bus2.dm_rdata_o, 32'hCAFE_0020);
            if (e_if) check($sformatf("t4 if_rdata c%0d", c), bus2.if_rdata_o, 32'h2010_0004);
            next_cycle();
            if (c == 16) begin bus2.if_req_i = 0; bus2.dm_req_i = 0; end
        end

        // ---- T5: reset during WAIT, then a normal access ----
        bus2.dm_req_i = 1; bus2.dm_we_i = 0; bus2.dm_addr_i = 32'h20;
        for (int c = 0; c <= 6; c++) begin
            @(negedge clk);
            if (c == 1) check("t5 mem_req issue", bus2.mem_req_o, 1);
            if (c == 3) begin
                check("t5 rst mem_addr", bus2.mem_addr_o, 0);
                check("t5 rst mem_we",   bus2.mem_we_o,   0);
                check("t5 rst if_rdata", bus2.if_rdata_o, 0);
                check("t5 rst dm_rdata", bus2.dm_rdata_o, 0);
            end
            if (c >= 3) begin
                check($sformatf("t5 dm_ack c%0d", c),  bus2.dm_ack_o,  0);
                check($sformatf("t5 mem_req c%0d", c), bus2.mem_req_o, 0);
            end
            next_cycle();
            if (c == 1) begin rst = 1; bus2.dm_req_i = 0; end
            if (c == 2) rst = 0;
        end
        bus2.if_req_i = 1; bus2.if_addr_i = 32'h10;
        for (int c = 0; c <= 5; c++) begin
            @(negedge clk);
            check($sformatf("t5b mem_req c%0d", c), bus2.mem_req_o, (c == 1));
            check($sformatf("t5b if_ack c%0d", c),  bus2.if_ack_o,  (c == 4));
            if (c == 4) check("t5b if_rdata", bus2.if_rdata_o, 32'h2010_0004);
            next_cycle();
            if (c == 4) bus2.if_req_i = 0;
        end

        // ---- T6: LATENCY=1 DM read of 0x80 ----
        bus1.dm_req_i = 1; bus1.dm_we_i = 0; bus1.dm_addr_i = 32'h80;
        for (int c = 0; c <= 5; c++) begin
            @(negedge clk);
            check($sformatf("t6 mem_req c%0d", c),  bus1.mem_req_o,  (c == 1));
            check($sformatf("t6 dm_ack c%0d", c),   bus1.dm_ack_o,   (c == 3));
            check($sformatf("t6 dm_stall c%0d", c), bus1.dm_stall_o, (c <= 2));
            if (c == 3) check("t6 dm_rdata", bus1.dm_rdata_o, 32'h0000_1234);
            next_cycle();
            if (c == 3) bus1.dm_req_i = 0;
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
